// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Y86-style fetch-stage PC selection and next-PC prediction, with an
//   optional return-address stack (RAS).
//
//   Build option: define FETCH_PC_RAS_EN to include the return-address
//   stack. Without it there is no stack storage, ret predicts f_valP and
//   ras_count is tied to 0.
//
//   Parameters
//     AW         address / PC width
//     RAS_DEPTH  stack entries (power of two, >= 2)
//   Ports
//     clk, reset        clock; synchronous active-high reset
//     f_stall           hold predPC register and stack this cycle
//     f_icode, f_need_reg, f_need_valC, f_valC
//                       decoded fields of the instruction at f_pc
//     M_icode, M_cnd, M_valA   memory-stage jump resolution
//     W_icode, W_valM          write-back-stage return resolution
//     f_pc              selected fetch address (combinational)
//     f_valP            fall-through address (combinational)
//     f_predPC          predicted next PC (combinational)
//     ras_count         number of valid stack entries
//
//   Handshake: there is no valid/ready pair; f_stall=1 means the current
//   fetch is not consumed, so neither predPC nor the stack advance.
module fetch_pc_unit #(
  parameter int AW        = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         f_stall,
  input  logic [3:0]                   f_icode,
  input  logic                         f_need_reg,
  input  logic                         f_need_valC,
  input  logic [AW-1:0]                f_valC,
  input  logic [3:0]                   M_icode,
  input  logic                         M_cnd,
  input  logic [AW-1:0]                M_valA,
  input  logic [3:0]                   W_icode,
  input  logic [AW-1:0]                W_valM,
  output logic [AW-1:0]                f_pc,
  output logic [AW-1:0]                f_valP,
  output logic [AW-1:0]                f_predPC,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] I_JXX  = 4'd7;
  localparam logic [3:0] I_CALL = 4'd8;
  localparam logic [3:0] I_RET  = 4'd9;

  logic [AW-1:0] pred_pc_q;
  logic          mispredict;
  logic          ras_hit;
  logic [AW-1:0] ras_top;

  assign mispredict = (M_icode == I_JXX) && !M_cnd;

  // Fetch address select: mispredicted jump beats return correction.
  always_comb begin
    f_pc = pred_pc_q;
    if (mispredict)            f_pc = M_valA;
    else if (W_icode == I_RET) f_pc = W_valM;
  end

  assign f_valP = f_pc + AW'(1) + AW'(f_need_reg) + (f_need_valC ? AW'(8) : AW'(0));

  always_comb begin
    f_predPC = f_valP;
    if (f_icode == I_JXX || f_icode == I_CALL) f_predPC = f_valC;
    else if (f_icode == I_RET && ras_hit)      f_predPC = ras_top;
  end

  always_ff @(posedge clk) begin
    if (reset)         pred_pc_q <= '0;
    else if (!f_stall) pred_pc_q <= f_predPC;
  end

`ifdef FETCH_PC_RAS_EN
  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] sp_q;      // next free slot; top is sp_q-1 (wraps)
  logic [CW-1:0] count_q;
  logic [PW-1:0] sp_eff;
  logic [CW-1:0] count_eff;
  logic          do_push;
  logic          do_pop;

  // A mispredict discards the stack before the corrected instruction's
  // own push/pop, so everything below works on the "effective" state.
  assign sp_eff    = mispredict ? '0 : sp_q;
  assign count_eff = mispredict ? '0 : count_q;
  assign ras_hit   = (count_eff != '0);
  assign ras_top   = ras_mem[sp_eff - PW'(1)];
  assign do_push   = !f_stall && (f_icode == I_CALL);
  assign do_pop    = !f_stall && (f_icode == I_RET) && ras_hit;
  assign ras_count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
    end else if (!f_stall) begin
      if (do_push) begin
        // When full, the write lands on the oldest slot (circular buffer).
        sp_q    <= sp_eff + PW'(1);
        count_q <= (count_eff == CW'(RAS_DEPTH)) ? count_eff : count_eff + CW'(1);
      end else if (do_pop) begin
        sp_q    <= sp_eff - PW'(1);
        count_q <= count_eff - CW'(1);
      end else begin
        sp_q    <= sp_eff;
        count_q <= count_eff;
      end
    end
  end

  // Entry storage needs no reset; count_q gates every read.
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[sp_eff] <= f_valP;
  end
`else
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
  assign ras_count = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam int AW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  typedef struct {
    logic          reset;
    logic          stall;
    logic [3:0]    icode;
    logic          need_reg;
    logic          need_valc;
    logic [AW-1:0] valc;
    logic [3:0]    m_icode;
    logic          m_cnd;
    logic [AW-1:0] m_vala;
    logic [3:0]    w_icode;
    logic [AW-1:0] w_valm;
  } in_t;

  typedef struct {
    in_t           in;
    logic [AW-1:0] e_pc;
    logic [AW-1:0] e_valp;
    logic [AW-1:0] e_pred;
  } vec_t;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, f_stall, f_need_reg, f_need_valC, M_cnd;
  logic [3:0]    f_icode, M_icode, W_icode;
  logic [AW-1:0] f_valC, M_valA, W_valM;
  logic [AW-1:0] f_pc, f_valP, f_predPC;
  logic [CW-1:0] ras_count;

  fetch_pc_unit #(.AW(AW), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .f_stall(f_stall),
    .f_icode(f_icode), .f_need_reg(f_need_reg), .f_need_valC(f_need_valC),
    .f_valC(f_valC), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .f_pc(f_pc), .f_valP(f_valP), .f_predPC(f_predPC), .ras_count(ras_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: predicted-PC register and a queue used as the stack
  logic [AW-1:0] m_pred;
  logic [AW-1:0] m_stk[$];
  logic [AW-1:0] e_pc, e_valp, e_pred;
  int            e_cnt;
  in_t           cur;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [3:0] icode, input logic nr, input logic nv,
                             input logic [AW-1:0] valc);
    in_t v;
    v.reset = 1'b0; v.stall = 1'b0;
    v.icode = icode; v.need_reg = nr; v.need_valc = nv; v.valc = valc;
    v.m_icode = 4'd0; v.m_cnd = 1'b1; v.m_vala = '0;
    v.w_icode = 4'd0; v.w_valm = '0;
    return v;
  endfunction

  task automatic drive(input in_t v);
    reset = v.reset; f_stall = v.stall; f_icode = v.icode;
    f_need_reg = v.need_reg; f_need_valC = v.need_valc; f_valC = v.valc;
    M_icode = v.m_icode; M_cnd = v.m_cnd; M_valA = v.m_vala;
    W_icode = v.w_icode; W_valM = v.w_valm;
  endtask

  // Expected outputs straight from the prediction rules.
  task automatic model_eval();
    bit mis;
    int live;
    mis  = (cur.m_icode == 4'd7) && !cur.m_cnd;
    e_pc = mis ? cur.m_vala : (cur.w_icode == 4'd9) ? cur.w_valm : m_pred;
    e_valp = e_pc + 1 + cur.need_reg + (cur.need_valc ? 8 : 0);
    live = mis ? 0 : m_stk.size();
    if (cur.icode == 4'd7 || cur.icode == 4'd8) e_pred = cur.valc;
    else if (cur.icode == 4'd9 && RAS_ON && live > 0) e_pred = m_stk[$];
    else e_pred = e_valp;
    e_cnt = m_stk.size();
  endtask

  task automatic model_update();
    if (cur.reset) begin
      m_pred = '0;
      m_stk.delete();
    end else if (!cur.stall) begin
      m_pred = e_pred;
      if (cur.m_icode == 4'd7 && !cur.m_cnd) m_stk.delete();
      if (RAS_ON && cur.icode == 4'd8) begin
        m_stk.push_back(e_valp);
        if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
      end else if (RAS_ON && cur.icode == 4'd9 && m_stk.size() > 0) begin
        void'(m_stk.pop_back());
      end
    end
  endtask

  // driver tasks: apply inputs at negedge, compare 1 time unit later
  task automatic apply(input in_t v);
    cur = v;
    drive(v);
    #1;
    model_eval();
    chk("model f_pc", f_pc, e_pc);
    chk("model f_valP", f_valP, e_valp);
    chk("model f_predPC", f_predPC, e_pred);
    chk("model ras_count", AW'(ras_count), AW'(e_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  vec_t          tbl[7];
  in_t           v;
  logic [AW-1:0] rets[DEPTH+1];
  logic [AW-1:0] exp_v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    v = mk(4'd0, 1'b0, 1'b0, '0);
    v.reset = 1'b1;
    cur = v;
    drive(v);
    repeat (2) @(posedge clk);
    m_pred = '0;
    m_stk.delete();
    @(negedge clk);
    apply(v);
    chk("reset f_pc", f_pc, '0);
    chk("reset ras_count", AW'(ras_count), '0);
    tick();

    // Single-cycle table, all stalled so predPC stays 0.
    tbl[0].in = mk(4'd0, 1'b0, 1'b0, '0);
    tbl[0].e_pc = 64'h0;  tbl[0].e_valp = 64'h1;  tbl[0].e_pred = 64'h1;
    tbl[1].in = mk(4'd3, 1'b1, 1'b1, 64'h5);
    tbl[1].in.m_icode = 4'd7; tbl[1].in.m_cnd = 1'b0; tbl[1].in.m_vala = 64'h10;
    tbl[1].e_pc = 64'h10; tbl[1].e_valp = 64'h1A; tbl[1].e_pred = 64'h1A;
    tbl[2].in = mk(4'd0, 1'b0, 1'b0, '0);
    tbl[2].in.m_icode = 4'd7; tbl[2].in.m_cnd = 1'b1; tbl[2].in.m_vala = 64'h10;
    tbl[2].in.w_icode = 4'd9; tbl[2].in.w_valm = 64'h50;
    tbl[2].e_pc = 64'h50; tbl[2].e_valp = 64'h51; tbl[2].e_pred = 64'h51;
    tbl[3].in = mk(4'd7, 1'b0, 1'b1, 64'h40);
    tbl[3].in.m_icode = 4'd7; tbl[3].in.m_cnd = 1'b0; tbl[3].in.m_vala = 64'h30;
    tbl[3].in.w_icode = 4'd9; tbl[3].in.w_valm = 64'h50;
    tbl[3].e_pc = 64'h30; tbl[3].e_valp = 64'h39; tbl[3].e_pred = 64'h40;
    tbl[4].in = mk(4'd8, 1'b0, 1'b1, 64'h200);
    tbl[4].in.w_icode = 4'd9; tbl[4].in.w_valm = 64'h100;
    tbl[4].e_pc = 64'h100; tbl[4].e_valp = 64'h109; tbl[4].e_pred = 64'h200;
    tbl[5].in = mk(4'd9, 1'b0, 1'b0, '0);
    tbl[5].in.m_icode = 4'd2; tbl[5].in.m_cnd = 1'b0; tbl[5].in.m_vala = 64'h77;
    tbl[5].in.w_icode = 4'd8; tbl[5].in.w_valm = 64'h88;
    tbl[5].e_pc = 64'h0; tbl[5].e_valp = 64'h1; tbl[5].e_pred = 64'h1;
    tbl[6].in = mk(4'd0, 1'b1, 1'b1, '0);
    tbl[6].in.m_icode = 4'd7; tbl[6].in.m_cnd = 1'b0; tbl[6].in.m_vala = '1;
    tbl[6].e_pc = '1; tbl[6].e_valp = 64'h9; tbl[6].e_pred = 64'h9;
    for (int i = 0; i < 7; i++) begin
      v = tbl[i].in;
      v.stall = 1'b1;
      apply(v);
      chk($sformatf("tbl%0d f_pc", i), f_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d f_valP", i), f_valP, tbl[i].e_valp);
      chk($sformatf("tbl%0d f_predPC", i), f_predPC, tbl[i].e_pred);
      tick();
    end

    // nop from reset
    v = mk(4'd0, 1'b0, 1'b0, '0);
    apply(v); chk("nop f_valP", f_valP, 64'h1); tick();
    apply(v); chk("nop next f_pc", f_pc, 64'h1); tick();

    // irmovq at 0x10, jXX to 0x40, call at 0x40, mispredict to 0x19
    v = mk(4'd3, 1'b1, 1'b1, 64'h5);
    v.m_icode = 4'd7; v.m_cnd = 1'b0; v.m_vala = 64'h10;
    apply(v); chk("irmovq f_valP", f_valP, 64'h1A); tick();
    v = mk(4'd7, 1'b0, 1'b1, 64'h40);
    apply(v); chk("jxx f_pc", f_pc, 64'h1A); tick();
    v = mk(4'd8, 1'b0, 1'b1, 64'h60);
    apply(v); chk("jxx target f_pc", f_pc, 64'h40); tick();
    v = mk(4'd0, 1'b0, 1'b0, '0);
    v.m_icode = 4'd7; v.m_cnd = 1'b0; v.m_vala = 64'h19;
    apply(v); chk("mispredict f_pc", f_pc, 64'h19); tick();
    v = mk(4'd0, 1'b0, 1'b0, '0);
    apply(v); chk("mispredict ras_count", AW'(ras_count), '0); tick();

    // call at 0x100 -> 0x200, then ret
    v = mk(4'd8, 1'b0, 1'b1, 64'h200);
    v.m_icode = 4'd7; v.m_cnd = 1'b0; v.m_vala = 64'h100;
    apply(v); chk("call f_valP", f_valP, 64'h109); tick();
    v = mk(4'd9, 1'b0, 1'b0, '0);
    apply(v);
    chk("call target f_pc", f_pc, 64'h200);
`ifdef FETCH_PC_RAS_EN
    exp_v = 64'h109;
    chk("call ras_count", AW'(ras_count), 64'h1);
`else
    exp_v = 64'h201;
`endif
    chk("ret f_predPC", f_predPC, exp_v);
    tick();
    v = mk(4'd0, 1'b0, 1'b0, '0);
    apply(v); chk("ret ras_count", AW'(ras_count), '0); tick();

    // DEPTH+1 nested calls then DEPTH+1 rets
    v = mk(4'd8, 1'b0, 1'b1, 64'h1000);
    v.m_icode = 4'd7; v.m_cnd = 1'b0; v.m_vala = 64'h100;
    apply(v); rets[0] = 64'h109; tick();
    for (int i = 1; i <= DEPTH; i++) begin
      v = mk(4'd8, 1'b0, 1'b1, AW'(i + 1) * 64'h1000);
      apply(v);
      chk($sformatf("nest call%0d f_pc", i), f_pc, AW'(i) * 64'h1000);
      rets[i] = AW'(i) * 64'h1000 + 64'h9;
      tick();
    end
`ifdef FETCH_PC_RAS_EN
    exp_v = AW'(DEPTH);
`else
    exp_v = '0;
`endif
    chk("nest full ras_count", AW'(ras_count), exp_v);
    for (int k = 0; k <= DEPTH; k++) begin
      v = mk(4'd9, 1'b0, 1'b0, '0);
      apply(v);
`ifdef FETCH_PC_RAS_EN
      exp_v = (k < DEPTH) ? rets[DEPTH-k] : rets[1] + 64'h1;
`else
      exp_v = AW'(DEPTH + 1) * 64'h1000 + AW'(k) + 64'h1;
`endif
      chk($sformatf("nest ret%0d f_predPC", k), f_predPC, exp_v);
      tick();
    end
    chk("nest empty ras_count", AW'(ras_count), '0);

    // M and W together, then 3 stalled cycles
    v = mk(4'd8, 1'b0, 1'b1, 64'h80);
    v.m_icode = 4'd7; v.m_cnd = 1'b0; v.m_vala = 64'h30;
    v.w_icode = 4'd9; v.w_valm = 64'h50;
    apply(v); chk("m_over_w f_pc", f_pc, 64'h30); tick();
`ifdef FETCH_PC_RAS_EN
    exp_v = 64'h1;
`else
    exp_v = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      v = mk(4'd8, 1'b0, 1'b1, 64'h999);
      v.stall = 1'b1;
      apply(v);
      chk($sformatf("stall%0d f_pc", i), f_pc, 64'h80);
      chk($sformatf("stall%0d ras_count", i), AW'(ras_count), exp_v);
      tick();
    end

    // call then ret, then return correction from W
    v = mk(4'd8, 1'b0, 1'b1, 64'h300);
    v.m_icode = 4'd7; v.m_cnd = 1'b0; v.m_vala = 64'h280;
    apply(v); tick();
    v = mk(4'd9, 1'b0, 1'b0, '0);
    apply(v);
`ifdef FETCH_PC_RAS_EN
    exp_v = 64'h289;
`else
    exp_v = 64'h301;
`endif
    chk("ret2 f_predPC", f_predPC, exp_v);
    tick();
    v = mk(4'd0, 1'b0, 1'b0, '0);
    v.w_icode = 4'd9; v.w_valm = 64'h55;
    apply(v); chk("w_fix f_pc", f_pc, 64'h55); tick();

    // reset beats stall and a concurrent call
    v = mk(4'd8, 1'b0, 1'b1, 64'h700);
    v.reset = 1'b1; v.stall = 1'b1;
    apply(v); tick();
    v = mk(4'd0, 1'b0, 1'b0, '0);
    apply(v);
    chk("reset2 f_pc", f_pc, '0);
    chk("reset2 ras_count", AW'(ras_count), '0);
    tick();

    // randomized stimulus against the model
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0: v = mk(4'd7, 1'b0, 1'b1, {$urandom, $urandom});
        1, 2: v = mk(4'd8, 1'b0, 1'b1, AW'($urandom_range(0, 65535)));
        3, 4: v = mk(4'd9, 1'b0, 1'b0, AW'($urandom));
        default: v = mk(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), AW'($urandom));
      endcase
      v.stall = ($urandom_range(0, 4) == 0);
      v.reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) begin
        v.m_icode = 4'd7; v.m_cnd = 1'b0; v.m_vala = {$urandom, $urandom};
      end else begin
        v.m_icode = 4'($urandom_range(0, 15)); v.m_cnd = 1'b1; v.m_vala = AW'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        v.w_icode = 4'd9; v.w_valm = {$urandom, $urandom};
      end else begin
        v.w_icode = 4'd0; v.w_valm = AW'($urandom);
      end
      apply(v);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
